kv_lookup_responder: RTL and testbench

//  Responder end of the key-query interface driven by eth_encap (in_key/in_flag/in_valid -> out_valid/out_flag).

---
 rtl/kv_lookup_responder.sv | 67 ++++++
 tb/tb_kv_lookup_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/kv_lookup_responder.sv
// kv_lookup_responder: direct-mapped on-chip key table answering eth_encap queries at fixed latency 2
module kv_lookup_responder #(
    parameter int KEY_SIZE = 96,
    parameter int IDX_W    = 8
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic [IDX_W:0]      occupancy
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int NCH   = (KEY_SIZE + IDX_W - 1) / IDX_W;
    localparam int PW    = NCH * IDX_W;
    localparam logic [3:0] HIT = 4'b0001, MISS = 4'b0010, DONE = 4'b0100, ERR = 4'b1000;
    logic [PW-1:0]       pad;
    logic [IDX_W-1:0]    idx, s1_idx;
    logic [KEY_SIZE-1:0] s1_key;
    logic [3:0]          s1_flag, res;
    logic                s1_v, hit, slot_v, do_ins, do_del;
    logic [DEPTH-1:0]    vld;
    logic [KEY_SIZE-1:0] keys [DEPTH];
    assign pad = PW'(in_key);
    always_comb begin
        idx = '0;
        for (int i = 0; i < NCH; i++) idx = idx ^ pad[i*IDX_W +: IDX_W];
    end
    // Table is read in S1 and written on the same edge that retires the query,
    // so the next query in S1 already sees the update without forwarding.
    always_comb begin
        slot_v = vld[s1_idx];
        hit    = slot_v && keys[s1_idx] == s1_key;
        res    = s1_flag == 4'b0001 ? (hit ? HIT : MISS) :
                 s1_flag == 4'b0010 ? ((!slot_v || hit) ? DONE : ERR) :
                 s1_flag == 4'b0100 ? (hit ? DONE : MISS) : ERR;
        do_ins = s1_v && s1_flag == 4'b0010 && !slot_v;
        do_del = s1_v && s1_flag == 4'b0100 && hit;
    end
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            s1_v      <= 1'b0;
            s1_key    <= '0;
            s1_flag   <= '0;
            s1_idx    <= '0;
            vld       <= '0;
            out_valid <= 1'b0;
            out_flag  <= '0;
            occupancy <= '0;
        end else begin
            s1_v      <= in_valid;
            s1_key    <= in_key;
            s1_flag   <= in_flag;
            s1_idx    <= idx;
            out_valid <= s1_v;
            if (s1_v) out_flag <= res;
            if (do_ins) vld[s1_idx] <= 1'b1;
            else if (do_del) vld[s1_idx] <= 1'b0;
            occupancy <= occupancy + (IDX_W+1)'(do_ins) - (IDX_W+1)'(do_del);
        end
    end
    always_ff @(posedge clk156) begin
        if (do_ins) keys[s1_idx] <= s1_key;
    end
endmodule

// File: tb/tb_kv_lookup_responder.sv
// tb_kv_lookup_responder: directed and random queries checked against a table model
module tb_kv_lookup_responder;
    localparam logic [3:0] LK = 4'b0001, INS = 4'b0010, DEL = 4'b0100;
    localparam logic [3:0] HIT = 4'b0001, MISS = 4'b0010, DONE = 4'b0100, ERR = 4'b1000;
    logic        clk156 = 0, eth_rst = 1, in_valid = 0, out_valid;
    logic [95:0] in_key = '0;
    logic [3:0]  in_flag = '0, out_flag;
    logic [8:0]  occupancy;
    int checks = 0, failures = 0;
    bit          mv [256];
    logic [95:0] mk [256];
    int          occ = 0;
    bit          pv [2];
    logic [3:0]  pf [2];
    int          po [2];
    logic [3:0]  obs [$];

    kv_lookup_responder dut (
        .clk156(clk156), .eth_rst(eth_rst), .in_key(in_key), .in_flag(in_flag),
        .in_valid(in_valid), .out_valid(out_valid), .out_flag(out_flag), .occupancy(occupancy)
    );

    always #5 clk156 = ~clk156;

    function automatic int h(logic [95:0] k);
        int r = 0;
        for (int i = 0; i < 12; i++) r = r ^ int'((k >> (8 * i)) & 96'hFF);
        return r;
    endfunction

    function automatic logic [3:0] model(logic [3:0] f, logic [95:0] k);
        int  i = h(k);
        bit  m = mv[i] && mk[i] == k;
        case (f)
            LK:  return m ? HIT : MISS;
            INS: begin
                if (mv[i]) return m ? DONE : ERR;
                mv[i] = 1; mk[i] = k; occ++;
                return DONE;
            end
            DEL: begin
                if (!m) return MISS;
                mv[i] = 0; occ--;
                return DONE;
            end
            default: return ERR;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mv[i] = 0;
        occ = 0;
        for (int i = 0; i < 2; i++) begin pv[i] = 0; pf[i] = 0; po[i] = 0; end
    endtask

    // One cycle: check what the query two cycles back produced, then drive the next one.
    task automatic cyc(input logic v, input logic [3:0] f, input logic [95:0] k);
        logic [3:0] r;
        @(negedge clk156);
        chk("out_valid", out_valid, pv[1]);
        chk("out_flag", out_flag, pf[1]);
        chk("occupancy", occupancy, po[1]);
        if (out_valid) obs.push_back(out_flag);
        in_valid = v; in_flag = f; in_key = k;
        r = pf[0];
        if (v) r = model(f, k);
        pv[1] = pv[0]; pf[1] = pf[0]; po[1] = po[0];
        pv[0] = v; pf[0] = r; po[0] = occ;
    endtask

    task automatic drain(string tag, int n, logic [15:0] exp, int occ_exp);
        repeat (3) cyc(0, 0, 0);
        chk({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < n; i++) chk({tag, "_flag"}, obs[i], exp[4*(n-1-i) +: 4]);
        chk({tag, "_occ"}, occupancy, occ_exp);
        obs.delete();
    endtask

    task automatic rst_now();
        eth_rst = 1; in_valid = 0;
        clear_model();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_flag", out_flag, 0);
        repeat (2) cyc(0, 0, 0);
        eth_rst = 0;
    endtask

    initial begin
        logic [3:0]  f;
        logic [95:0] k;
        int          r;
        clear_model();
        #2;
        rst_now();
        cyc(1, LK, 96'h1);
        drain("t1", 1, {MISS}, 0);
        cyc(1, INS, 96'h1); cyc(1, LK, 96'h1);
        drain("t2", 2, {DONE, HIT}, 1);
        cyc(1, INS, 96'h0); cyc(1, INS, 96'h101); cyc(1, LK, 96'h101);
        drain("t3", 3, {DONE, ERR, MISS}, 2);
        cyc(1, DEL, 96'h1); cyc(1, DEL, 96'h1); cyc(1, LK, 96'h1);
        drain("t4", 3, {DONE, MISS, MISS}, 1);
        cyc(1, 4'b0011, 96'h0); cyc(1, LK, 96'h0);
        drain("t5", 2, {ERR, HIT}, 1);
        for (int i = 0; i < 256; i++) cyc(1, INS, 96'(i));
        repeat (3) cyc(0, 0, 0);
        chk("t6_count", obs.size(), 256);
        chk("t6_occ", occupancy, 256);
        obs.delete();
        cyc(1, LK, 96'h5); cyc(1, DEL, 96'h6);
        rst_now();
        cyc(1, LK, 96'h5);
        drain("t6_rst", 1, {MISS}, 0);
        for (int n = 0; n < 10000; n++) begin
            r = $urandom_range(0, 15);
            k = 96'($urandom_range(0, 1023)) | (96'($urandom_range(0, 1)) << 80);
            f = r < 6 ? LK : r < 11 ? INS : r < 14 ? DEL : 4'($urandom_range(8, 15));
            cyc(r != 15, f, k);
        end
        repeat (3) cyc(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
